// File: rtl/clock.sv
// clock: 24-hour HH:MM clock on a 4-digit, common-anode, multiplexed
// seven-segment display, with a debounced minute-advance button and a
// 4-level PWM brightness select.
//
// Optional feature macro: COLON_BLINK_EN
//   defined   - the digit-2 decimal point blinks as the hours/minutes
//               separator (lit while the prescaler is in the first half
//               of the second), gated by brightness like the anode.
//   undefined - all decimal points stay dark.
module clock #(
    parameter int CLK_HZ          = 100_000_000,
    parameter int DIGIT_CYCLES    = 100_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       Clk_100M,
    input  logic       Reset,
    input  logic       button,
    input  logic [1:0] Slide_Switch,
    output logic [3:0] SegmentDrivers,
    output logic [7:0] SevenSegment
);

    localparam int NUM_DIGITS = 4;
    localparam int QUARTER    = DIGIT_CYCLES / 4;
    localparam int PW = (CLK_HZ > 1)          ? $clog2(CLK_HZ)          : 1;
    localparam int QW = (QUARTER > 1)         ? $clog2(QUARTER)         : 1;
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
    localparam logic [QW-1:0] QCNT_MAX  = QW'(QUARTER - 1);
    localparam logic [DW-1:0] DB_MAX    = DW'(DEBOUNCE_CYCLES - 1);

    // ------------------------------------------------------------------
    // Time state (BCD)
    // ------------------------------------------------------------------
    logic [PW-1:0] presc;
    logic [3:0]    sec_t, sec_u, min_t, min_u, hr_t, hr_u;
    logic [3:0]    min_t_n, min_u_n, hr_t_n, hr_u_n;
    logic          tick, sec_wrap, min_step;

    // ------------------------------------------------------------------
    // Button path
    // ------------------------------------------------------------------
    logic [1:0]    btn_sync;
    logic          db_level, db_prev;
    logic [DW-1:0] db_cnt;
    logic          press;

    // ------------------------------------------------------------------
    // Scan / brightness
    // ------------------------------------------------------------------
    logic [QW-1:0] q_cnt;
    logic [1:0]    quarter;
    logic [1:0]    sel;
    logic [1:0]    bright;
    logic          slot_start;
    logic          dp_n;

    logic [NUM_DIGITS-1:0][3:0] bcd;
    logic [NUM_DIGITS-1:0][6:0] glyph;

    assign tick     = (presc == PRESC_MAX);
    assign sec_wrap = tick && (sec_t == 4'd5) && (sec_u == 4'd9);
    assign press    = db_level && !db_prev;
    // A press takes the minute step itself; the coincident tick is dropped
    // because the press branch below ignores it.
    assign min_step = press || sec_wrap;

    // Time one minute ahead, shared by the seconds carry and the button
    always_comb begin
        min_u_n = min_u + 4'd1;
        min_t_n = min_t;
        hr_u_n  = hr_u;
        hr_t_n  = hr_t;
        if (min_u == 4'd9) begin
            min_u_n = 4'd0;
            if (min_t == 4'd5) begin
                min_t_n = 4'd0;
                if (hr_t == 4'd2 && hr_u == 4'd3) begin
                    hr_t_n = 4'd0;
                    hr_u_n = 4'd0;
                end else if (hr_u == 4'd9) begin
                    hr_u_n = 4'd0;
                    hr_t_n = hr_t + 4'd1;
                end else begin
                    hr_u_n = hr_u + 4'd1;
                end
            end else begin
                min_t_n = min_t + 4'd1;
            end
        end
    end

    // Prescaler, seconds and the minute/hour carry chain
    always_ff @(posedge Clk_100M or posedge Reset) begin
        if (Reset) begin
            presc <= '0;
            sec_t <= 4'd0;
            sec_u <= 4'd0;
            min_t <= 4'd0;
            min_u <= 4'd0;
            hr_t  <= 4'd0;
            hr_u  <= 4'd0;
        end else begin
            if (press) begin
                presc <= '0;
                sec_t <= 4'd0;
                sec_u <= 4'd0;
            end else begin
                presc <= tick ? '0 : presc + 1'b1;
                if (tick) begin
                    if (sec_u == 4'd9) begin
                        sec_u <= 4'd0;
                        sec_t <= (sec_t == 4'd5) ? 4'd0 : sec_t + 4'd1;
                    end else begin
                        sec_u <= sec_u + 4'd1;
                    end
                end
            end
            if (min_step) begin
                min_t <= min_t_n;
                min_u <= min_u_n;
                hr_t  <= hr_t_n;
                hr_u  <= hr_u_n;
            end
        end
    end

    // Two-flop synchroniser for the asynchronous button
    always_ff @(posedge Clk_100M or posedge Reset) begin
        if (Reset) btn_sync <= 2'b00;
        else       btn_sync <= {btn_sync[0], button};
    end

    // Debouncer: accept a new level only after it has persisted long enough
    always_ff @(posedge Clk_100M or posedge Reset) begin
        if (Reset) begin
            db_level <= 1'b0;
            db_cnt   <= '0;
        end else if (btn_sync[1] == db_level) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_MAX) begin
            db_level <= btn_sync[1];
            db_cnt   <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    // Previous debounced level for rising-edge detection
    always_ff @(posedge Clk_100M or posedge Reset) begin
        if (Reset) db_prev <= 1'b0;
        else       db_prev <= db_level;
    end

    // Scan counter: quarter sub-counter, quarter index, digit select;
    // brightness is resampled at every quarter boundary
    always_ff @(posedge Clk_100M or posedge Reset) begin
        if (Reset) begin
            q_cnt   <= '0;
            quarter <= 2'd0;
            sel     <= 2'd0;
            bright  <= 2'd0;
        end else if (q_cnt == QCNT_MAX) begin
            q_cnt   <= '0;
            quarter <= quarter + 2'd1;
            bright  <= Slide_Switch;
            if (quarter == 2'd3) sel <= sel + 2'd1;
        end else begin
            q_cnt <= q_cnt + 1'b1;
        end
    end

    assign slot_start = (q_cnt == '0) && (quarter == 2'd0);

    // Digit 3..0 = hours tens, hours units, minutes tens, minutes units
    assign bcd = {hr_t, hr_u, min_t, min_u};

    genvar g;
    generate
        for (g = 0; g < NUM_DIGITS; g++) begin : g_dec
            // BCD to active-low {g,f,e,d,c,b,a}
            always_comb begin
                case (bcd[g])
                    4'd0:    glyph[g] = 7'h40;
                    4'd1:    glyph[g] = 7'h79;
                    4'd2:    glyph[g] = 7'h24;
                    4'd3:    glyph[g] = 7'h30;
                    4'd4:    glyph[g] = 7'h19;
                    4'd5:    glyph[g] = 7'h12;
                    4'd6:    glyph[g] = 7'h02;
                    4'd7:    glyph[g] = 7'h78;
                    4'd8:    glyph[g] = 7'h00;
                    4'd9:    glyph[g] = 7'h10;
                    default: glyph[g] = 7'h7F;
                endcase
            end
        end
    endgenerate

`ifdef COLON_BLINK_EN
    localparam logic [PW-1:0] PRESC_HALF = PW'(CLK_HZ / 2);
    assign dp_n = !((sel == 2'd2) && (presc < PRESC_HALF));
`else
    assign dp_n = 1'b1;
`endif

    // Registered pins: anode gated by quarter vs brightness, glyph latched
    // once per slot so a time change shows on the next selection
    always_ff @(posedge Clk_100M or posedge Reset) begin
        if (Reset) begin
            SegmentDrivers <= 4'b1111;
            SevenSegment   <= 8'hFF;
        end else begin
            SegmentDrivers <= (quarter <= bright) ? ~(4'b0001 << sel) : 4'b1111;
            if (slot_start) SevenSegment[6:0] <= glyph[sel];
            SevenSegment[7] <= dp_n;
        end
    end

endmodule

// File: tb/tb_clock.sv
// tb_clock: scoreboard bench for the clock display. Stimulus pushes the
// expected glyph for each digit of a display frame; a monitor pops one entry
// whenever the DUT selects that digit and compares it.
module tb_clock;

    localparam int CLK_HZ          = 40;
    localparam int DIGIT_CYCLES    = 8;
    localparam int DEBOUNCE_CYCLES = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       button = 1'b0;
    logic [1:0] sw = 2'b11;
    logic [3:0] an;
    logic [7:0] seg;

    clock #(
        .CLK_HZ(CLK_HZ),
        .DIGIT_CYCLES(DIGIT_CYCLES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) dut (
        .Clk_100M(clk),
        .Reset(rst),
        .button(button),
        .Slide_Switch(sw),
        .SegmentDrivers(an),
        .SevenSegment(seg)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int         dig;
        logic [7:0] seg;
    } exp_t;

    exp_t  exp_q[$];
    string cur_name = "init";
    int    model_sec;

    function automatic logic [7:0] glyph_of(int v);
        case (v)
            0: return 8'hC0;
            1: return 8'hF9;
            2: return 8'hA4;
            3: return 8'hB0;
            4: return 8'h99;
            5: return 8'h92;
            6: return 8'h82;
            7: return 8'hF8;
            8: return 8'h80;
            9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic int dig_of(logic [3:0] a);
        case (a)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return -1;
        endcase
    endfunction

    function automatic bit seg_ok(int d, logic [7:0] act, logic [7:0] req);
`ifdef COLON_BLINK_EN
        if (d == 2) return act[6:0] == req[6:0];
`endif
        return act == req;
    endfunction

    // Monitor: one-hot anode, scan order, and frame scoreboard
    int prev_dig = -1;
    always @(negedge clk) begin
        int   d;
        exp_t e;
        if (rst) begin
            prev_dig = -1;
        end else if (an != 4'b1111) begin
            d = dig_of(an);
            checks++;
            if (d < 0) begin
                errors++;
                $display("FAIL onehot actual=%b required=one bit low", an);
            end else if (d != prev_dig) begin
                if (prev_dig >= 0) begin
                    checks++;
                    if (d != (prev_dig + 1) % 4) begin
                        errors++;
                        $display("FAIL scan_order actual=%0d required=%0d", d, (prev_dig + 1) % 4);
                    end
                end
                prev_dig = d;
                if (exp_q.size() > 0 && exp_q[0].dig == d) begin
                    e = exp_q.pop_front();
                    checks++;
                    if (!seg_ok(d, seg, e.seg)) begin
                        errors++;
                        $display("FAIL %s digit%0d actual=%h required=%h", cur_name, d, seg, e.seg);
                    end
                end
            end
        end
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Queue the expected HH:MM frame from the model and wait for the monitor
    task automatic frame(string name);
        int mm;
        int hh;
        exp_t e;
        mm = (model_sec / 60) % 60;
        hh = model_sec / 3600;
        cur_name = name;
        e.dig = 0; e.seg = glyph_of(mm % 10); exp_q.push_back(e);
        e.dig = 1; e.seg = glyph_of(mm / 10); exp_q.push_back(e);
        e.dig = 2; e.seg = glyph_of(hh % 10); exp_q.push_back(e);
        e.dig = 3; e.seg = glyph_of(hh / 10); exp_q.push_back(e);
        for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL %s frame_timeout pending=%0d required=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic press(int hold, int rel);
        @(negedge clk);
        button = 1'b1;
        repeat (hold) @(negedge clk);
        button = 1'b0;
        repeat (rel) @(negedge clk);
    endtask

    function automatic void model_press();
        model_sec = ((model_sec / 60 + 1) % 1440) * 60;
    endfunction

    // Count anode-low cycles per digit over four whole scan periods
    task automatic brightness(logic [1:0] s);
        int cnt[4];
        sw = s;
        repeat (64) @(negedge clk);
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        repeat (4 * 4 * DIGIT_CYCLES) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) if (!an[i]) cnt[i]++;
        end
        for (int i = 0; i < 4; i++)
            check($sformatf("bright%0d_dig%0d", s, i), cnt[i],
                  4 * (DIGIT_CYCLES / 4) * (int'(s) + 1));
    endtask

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rel;
        int p0;
        int cnt_press;
        model_sec = 0;
        rst = 1'b1;
        sw  = 2'b11;
        repeat (3) @(negedge clk);
        check("reset_an", an, 4'hF);
        check("reset_seg", seg, 8'hFF);

        rst = 1'b0;
        rel = cyc;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (k == 1) begin
                check("first_an", an, 4'b1110);
                check("first_seg", seg, 8'hC0);
            end
`ifdef COLON_BLINK_EN
            if (an == 4'b1011)
                check("colon_dp", seg[7], (((k - 1) % CLK_HZ) < CLK_HZ / 2) ? 0 : 1);
`endif
        end
        frame("zero");

        // 60 ticks after release: minutes roll to 01
        while (cyc - rel < 60 * CLK_HZ + 50) @(posedge clk);
        model_sec = 61;
        frame("rollover_0001");

        brightness(2'b00);
        brightness(2'b01);
        brightness(2'b10);
        brightness(2'b11);

        // Long press: one minute, seconds cleared
        p0 = cyc;
        press(20, 20);
        model_press();
        frame("press");
        press(2, 20);
        frame("glitch");
        while (cyc - p0 < 2200) @(posedge clk);
        frame("sec_cleared");
        while (cyc - p0 < 2500) @(posedge clk);
        model_sec = model_sec + 60;
        frame("after_press_min");

        // Asynchronous reset mid-operation
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midreset_an", an, 4'hF);
        check("midreset_seg", seg, 8'hFF);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_sec = 0;
        frame("after_reset");

        // Walk the clock to 12:34, then to 23:59, by presses
        for (cnt_press = 0; cnt_press < 754; cnt_press++) begin
            press(8, 8);
            model_press();
        end
        frame("t1234");
        for (cnt_press = 0; cnt_press < 685; cnt_press++) begin
            p0 = cyc;
            press(8, 8);
            model_press();
        end
        frame("t2359");
        while (cyc - p0 < 60 * CLK_HZ + 50) @(posedge clk);
        model_sec = (model_sec + 60) % 86400;
        frame("wrap_0000");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
